// File: rtl/cgra_config_loader.sv
// cgra_config_loader: streams bitstream (addr,data) words into the CGRA config port.
// Define CFG_LOADER_VERIFY_EN to add a per-word readback compare (READ/ERROR states).
module cgra_config_loader #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STALL_W     = 4,
  parameter int STALL_SETUP = 2,
  parameter int READ_LAT    = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               bs_valid,
  output logic               bs_ready,
  input  logic [ADDR_W-1:0]  bs_addr,
  input  logic [DATA_W-1:0]  bs_data,
  input  logic               bs_last,
  output logic [ADDR_W-1:0]  config_config_addr,
  output logic [DATA_W-1:0]  config_config_data,
  output logic               config_write,
  output logic               config_read,
  input  logic [DATA_W-1:0]  read_config_data,
  output logic [STALL_W-1:0] stall,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  err_addr,
  output logic [CNT_W-1:0]   word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCEPT,
    S_WRITE,
`ifdef CFG_LOADER_VERIFY_EN
    S_READ,
    S_ERROR,
`endif
    S_DONE
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(STALL_SETUP - 1);

  state_t              state_q, state_d;
  logic [3:0]          setup_cnt_q, setup_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic                can_start;
  logic                stall_on;

`ifdef CFG_LOADER_VERIFY_EN
  localparam logic [2:0] READ_LAST = 3'(READ_LAT - 1);

  logic [2:0]          rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
`else
  logic                unused_rd;
  assign unused_rd = ^read_config_data;
`endif

  always_comb begin
    can_start = (state_q == S_IDLE) || (state_q == S_DONE);
    stall_on  = (state_q == S_SETUP) || (state_q == S_ACCEPT)
             || (state_q == S_WRITE);
`ifdef CFG_LOADER_VERIFY_EN
    can_start = can_start || (state_q == S_ERROR);
    stall_on  = stall_on || (state_q == S_READ) || (state_q == S_ERROR);
`endif
  end

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_d      = last_q;
    word_cnt_d  = word_cnt_q;
`ifdef CFG_LOADER_VERIFY_EN
    rd_cnt_d    = rd_cnt_q;
    err_addr_d  = err_addr_q;
`endif
    // abort beats start, and start only counts when no load is running
    if (abort) begin
      state_d = S_IDLE;
    end else if (start && can_start) begin
      state_d     = S_SETUP;
      setup_cnt_d = '0;
      word_cnt_d  = '0;
`ifdef CFG_LOADER_VERIFY_EN
      err_addr_d  = '0;
`endif
    end else begin
      unique case (state_q)
        S_SETUP: begin
          if (setup_cnt_q == SETUP_LAST) state_d = S_ACCEPT;
          else setup_cnt_d = setup_cnt_q + 4'd1;
        end
        S_ACCEPT: begin
          if (bs_valid) begin
            addr_d  = bs_addr;
            data_d  = bs_data;
            last_d  = bs_last;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
`ifdef CFG_LOADER_VERIFY_EN
          rd_cnt_d = '0;
          state_d  = S_READ;
`else
          state_d  = last_q ? S_DONE : S_ACCEPT;
`endif
        end
`ifdef CFG_LOADER_VERIFY_EN
        S_READ: begin
          if (rd_cnt_q == READ_LAST) begin
            if (read_config_data != data_q) begin
              err_addr_d = addr_q;
              state_d    = S_ERROR;
            end else begin
              state_d = last_q ? S_DONE : S_ACCEPT;
            end
          end else begin
            rd_cnt_d = rd_cnt_q + 3'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      setup_cnt_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      word_cnt_q  <= '0;
`ifdef CFG_LOADER_VERIFY_EN
      rd_cnt_q    <= '0;
      err_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      word_cnt_q  <= word_cnt_d;
`ifdef CFG_LOADER_VERIFY_EN
      rd_cnt_q    <= rd_cnt_d;
      err_addr_q  <= err_addr_d;
`endif
    end
  end

  assign bs_ready           = (state_q == S_ACCEPT);
  assign config_write       = (state_q == S_WRITE);
  assign config_config_addr = addr_q;
  assign config_config_data = data_q;
  assign stall              = {STALL_W{stall_on}};
  assign done               = (state_q == S_DONE);
  assign word_cnt           = word_cnt_q;

`ifdef CFG_LOADER_VERIFY_EN
  assign config_read = (state_q == S_READ);
  assign error       = (state_q == S_ERROR);
  assign err_addr    = err_addr_q;
  assign busy        = stall_on && (state_q != S_ERROR);
`else
  assign config_read = 1'b0;
  assign error       = 1'b0;
  assign err_addr    = '0;
  assign busy        = stall_on;
`endif

endmodule

// File: tb/tb_cgra_config_loader.sv
// Bench for cgra_config_loader: table-driven word stream with a write scoreboard.
// Readback cases run only when CFG_LOADER_VERIFY_EN is defined.
module tb_cgra_config_loader;

`ifdef CFG_LOADER_VERIFY_EN
  localparam int CPW = 3;
`else
  localparam int CPW = 2;
`endif

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic        bs_valid, bs_ready, bs_last;
  logic [31:0] bs_addr, bs_data;
  logic [31:0] cfg_addr, cfg_data, read_config_data, err_addr;
  logic        cfg_write, cfg_read;
  logic [3:0]  stall;
  logic        busy, done, error;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  cgra_config_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .bs_valid(bs_valid), .bs_ready(bs_ready), .bs_addr(bs_addr),
    .bs_data(bs_data), .bs_last(bs_last),
    .config_config_addr(cfg_addr), .config_config_data(cfg_data),
    .config_write(cfg_write), .config_read(cfg_read),
    .read_config_data(read_config_data), .stall(stall), .busy(busy),
    .done(done), .error(error), .err_addr(err_addr), .word_cnt(word_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
    int          gap;
    int          exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t        tbl[6];
  wr_t         sb[$];
  wr_t         exp_w;
  int          wr_times[$];
  int          wr_cnt = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          base;
  logic        prev_write = 1'b0;
  logic        corrupt = 1'b0;
  logic [31:0] mem[16];

  // Interconnect model: stores writes, returns them on readback
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cfg_write) mem[cfg_addr[19:16]] <= cfg_data;
  end

  always_comb begin
    read_config_data = mem[cfg_addr[19:16]];
    if (corrupt && cfg_addr == 32'h0002_0001) read_config_data = 32'hBC;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && cfg_write) begin
      wr_cnt++;
      wr_times.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 cfg_addr, cfg_data);
      end else begin
        exp_w = sb.pop_front();
        chk("write_addr", cfg_addr, exp_w.addr);
        chk("write_data", cfg_data, exp_w.data);
      end
      chk("write_pulse_excl", {cfg_read, prev_write}, 0);
    end
    prev_write = cfg_write;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_word(input vec_t v, input bit do_abort);
    int to;
    bit ok;
    if (v.gap > 0) begin
      bs_valid = 1'b0;
      repeat (v.gap) @(posedge clk);
      #1;
    end
    bs_valid = 1'b1;
    bs_addr  = v.addr;
    bs_data  = v.data;
    bs_last  = v.last;
    ok = 1'b0;
    to = 0;
    while (!ok && to < 60) begin
      @(negedge clk);
      to++;
      ok = bs_ready;
    end
    if (!ok) begin
      chk("ready_timeout", ok, 1);
      bs_valid = 1'b0;
      return;
    end
    chk("cnt_at_accept", word_cnt, v.exp_cnt);
    if (do_abort) abort = 1'b1;
    else sb.push_back('{v.addr, v.data});
    @(posedge clk); #1;
    abort = 1'b0;
    if (v.last || do_abort) bs_valid = 1'b0;
  endtask

  task automatic wait_end();
    int to = 0;
    while (!(done || error) && to < 60) begin
      @(negedge clk);
      to++;
    end
  endtask

  initial begin
    tbl[0] = '{32'h0001_0001, 32'hAA, 1'b0, 0, 0};
    tbl[1] = '{32'h0002_0001, 32'hBB, 1'b0, 0, 1};
    tbl[2] = '{32'h0003_0001, 32'hCC, 1'b1, 0, 2};
    tbl[3] = '{32'h0001_0001, 32'h11, 1'b0, 5, 0};
    tbl[4] = '{32'h0002_0001, 32'h22, 1'b0, 5, 1};
    tbl[5] = '{32'h0003_0001, 32'h33, 1'b1, 5, 2};
    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    bs_valid = 1'b0; bs_last = 1'b0; bs_addr = '0; bs_data = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // T1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t1_ctrl", {stall, bs_ready, cfg_write, cfg_read, busy, done, error}, 0);
      chk("t1_cfg", {cfg_addr, cfg_data}, 0);
      chk("t1_err_cnt", {err_addr, word_cnt}, 0);
    end

    // T2/T3: three words back to back
    wr_times.delete();
    base = wr_cnt;
    pulse_start();
    @(negedge clk);
    chk("t2_setup_stall0", stall, 4'hF);
    chk("t2_setup_busy0", {busy, bs_ready}, 2'b10);
    @(negedge clk);
    chk("t2_setup_stall1", stall, 4'hF);
    chk("t2_setup_busy1", {busy, bs_ready}, 2'b10);
    for (int i = 0; i < 3; i++) send_word(tbl[i], 1'b0);
    wait_end();
    chk("t2_done", {done, error}, 2'b10);
    chk("t2_word_cnt", word_cnt, 3);
    chk("t2_nwrites", wr_cnt - base, 3);
    chk("t2_sb_empty", sb.size(), 0);
    if (wr_times.size() == 3) begin
      chk("t2_rate01", wr_times[1] - wr_times[0], CPW);
      chk("t2_rate12", wr_times[2] - wr_times[1], CPW);
    end
    @(negedge clk);
    chk("t2_stall_released", {stall, busy, done}, 6'b0_0000_1);

`ifdef CFG_LOADER_VERIFY_EN
    // T4: word 2 reads back corrupted
    corrupt = 1'b1;
    base = wr_cnt;
    pulse_start();
    send_word(tbl[0], 1'b0);
    send_word(tbl[1], 1'b0);
    bs_valid = 1'b0;
    wait_end();
    chk("t4_flags", {error, done, busy}, 3'b100);
    chk("t4_err_addr", err_addr, 32'h0002_0001);
    chk("t4_stall", stall, 4'hF);
    repeat (5) @(negedge clk);
    chk("t4_no_third_write", wr_cnt - base, 2);
    chk("t4_sticky", {error, stall, bs_ready}, 6'b1_1111_0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t4_abort_clear", {error, stall, busy}, 0);
    corrupt = 1'b0;
`endif

    // T5: abort on the second word's accept cycle
    base = wr_cnt;
    pulse_start();
    send_word(tbl[0], 1'b0);
    send_word(tbl[1], 1'b1);
    @(negedge clk);
    chk("t5_idle", {busy, stall, cfg_write, cfg_read, done, error}, 0);
    chk("t5_word_cnt", word_cnt, 1);
    repeat (5) @(negedge clk);
    chk("t5_nwrites", wr_cnt - base, 1);
    chk("t5_sb_empty", sb.size(), 0);

    // T6: gapped stream with a start pulse mid-load
    base = wr_cnt;
    pulse_start();
    fork
      for (int i = 3; i < 6; i++) send_word(tbl[i], 1'b0);
      begin
        repeat (10) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        chk("t6_busy_after_start", {busy, stall}, 5'b1_1111);
      end
    join
    wait_end();
    chk("t6_done", {done, error}, 2'b10);
    chk("t6_word_cnt", word_cnt, 3);
    chk("t6_nwrites", wr_cnt - base, 3);
    chk("t6_sb_empty", sb.size(), 0);

    // reset in the middle of a load
    pulse_start();
    repeat (3) @(negedge clk);
    chk("rst_pre_stall", stall, 4'hF);
    reset = 1'b1;
    #1;
    chk("rst_mid_load", {stall, busy, bs_ready, done}, 0);
    chk("rst_mid_cnt", {word_cnt, cfg_addr}, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
